digit_scan_driver: RTL

//  Parametrised multiplexed 7-segment scan driver, successor to the fixed 4-digit anode scanner.

---
 rtl/digit_scan_pkg.sv | 11 +
 rtl/seg7_decoder.sv | 9 +
 rtl/digit_scan_driver.sv | 99 +++++++++
 3 files changed

// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: active-low hex segment table, blank pattern and width helper
package digit_scan_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic int clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: 4-bit hex nibble to active-low {g,f,e,d,c,b,a} cathode pattern
module seg7_decoder
  import digit_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_HEX[nibble];
endmodule

// File: rtl/digit_scan_driver.sv
// digit_scan_driver: multiplexed 7-segment scanner with dead time, PWM brightness and hex decode; DIGIT_SCAN_LZB_EN enables leading-zero blanking
module digit_scan_driver
  import digit_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int DIGIT_HZ     = 1_000,
  parameter int BLANK_CYCLES = 1_000,
  parameter int BRIGHT_W     = 4
) (
  input  logic                          clk_100MHz,
  input  logic                          reset_n,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [BRIGHT_W-1:0]           brightness,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [clog2(NUM_DIGITS)-1:0]  digit_idx,
  output logic                          slot_start
);
  localparam int SLOT_CYCLES = CLK_HZ / DIGIT_HZ;
  localparam int TW = clog2(SLOT_CYCLES);
  localparam int IW = clog2(NUM_DIGITS);
  localparam logic [31:0] STEP = 32'((SLOT_CYCLES - BLANK_CYCLES) >> BRIGHT_W);
  localparam logic [31:0] BL = 32'(BLANK_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  if (SLOT_CYCLES < BLANK_CYCLES + 2**BRIGHT_W || NUM_DIGITS < 1) begin : g_cfg_err
    $error("digit_scan_driver: slot too short for dead time plus brightness steps, or no digits");
  end
  logic [TW-1:0]       timer;
  logic [3:0]          nib_q;
  logic                dp_q, en_q, blank_q;
  logic [BRIGHT_W-1:0] bright_q;
  logic                wrap, lit, hi_zero;
  logic [IW-1:0]       nxt_idx;
  logic [3:0]          nxt_nib;
  logic                nxt_dp, nxt_en, nxt_blank;
  logic [31:0]         on_end;
  logic [6:0]          dec;
  seg7_decoder u_dec (.nibble(nib_q), .seg(dec));
  assign wrap    = timer == LAST;
  assign nxt_idx = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
  assign on_end  = BL + STEP * (32'(bright_q) + 32'd1);
  assign lit     = en_q && !blank_q && 32'(timer) >= BL && 32'(timer) < on_end;
  // select the incoming digit's nibble/flags and, with blanking on, whether it and all higher nibbles are zero
  always_comb begin
    nxt_nib = '0;
    nxt_dp = 1'b0;
    nxt_en = 1'b0;
    nxt_blank = 1'b0;
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef DIGIT_SCAN_LZB_EN
      hi_zero = hi_zero && digits[4*i +: 4] == 4'd0;
`endif
      if (IW'(i) == nxt_idx) begin
        nxt_nib = digits[4*i +: 4];
        nxt_dp = dp_in[i];
        nxt_en = digit_en[i];
`ifdef DIGIT_SCAN_LZB_EN
        nxt_blank = i > 0 && hi_zero && !dp_in[i];
`endif
      end
    end
  end
  // slot timer, digit index, per-slot latches and registered pin drive
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
      digit_idx <= '0;
      slot_start <= 1'b0;
      nib_q <= '0;
      dp_q <= 1'b0;
      en_q <= 1'b0;
      blank_q <= 1'b0;
      bright_q <= '1;
      anode <= '1;
      seg <= SEG_OFF;
      dp <= 1'b1;
    end else begin
      timer <= wrap ? '0 : timer + 1'b1;
      slot_start <= wrap;
      if (wrap) begin
        digit_idx <= nxt_idx;
        nib_q <= nxt_nib;
        dp_q <= nxt_dp;
        en_q <= nxt_en;
        blank_q <= nxt_blank;
        bright_q <= brightness;
      end
      anode <= lit ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
      seg <= lit ? dec : SEG_OFF;
      dp <= !(lit && dp_q);
    end
  end
endmodule
